// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: paces buffered ADC samples into an FFT core and reports the largest non-DC bin.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i run enable (low aborts a frame);
//   adc_data_valid_i/adc_data_i sample strobe and data; fft_reset_o/fft_in_valid_o/fft_in_real_o FFT feed;
//   fft_done_i/mag_ready_i/mag_i FFT result stream; peak_valid_o/peak_bin_o/peak_mag_o peak report;
//   busy_o high outside IDLE; overflow_o sticky flag for a dropped sample.
module fft_frame_sequencer #(
  parameter int FFT_LENGTH     = 1024,
  parameter int MAG_BINS       = 512,
  parameter int SAMPLE_GAP     = 21,
  parameter int FFT_RST_CYCLES = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        adc_data_valid_i,
  input  logic [11:0]                 adc_data_i,
  output logic                        fft_reset_o,
  output logic                        fft_in_valid_o,
  output logic [15:0]                 fft_in_real_o,
  input  logic                        fft_done_i,
  input  logic                        mag_ready_i,
  input  logic [15:0]                 mag_i,
  output logic                        peak_valid_o,
  output logic [$clog2(MAG_BINS)-1:0] peak_bin_o,
  output logic [15:0]                 peak_mag_o,
  output logic                        busy_o,
  output logic                        overflow_o
);
  localparam int LW = $clog2(FFT_LENGTH);
  localparam int BW = $clog2(MAG_BINS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(SAMPLE_GAP + 1);
  localparam int RW = $clog2(FFT_RST_CYCLES + 1);
  localparam logic [LW-1:0] LAST_ISSUE = LW'(FFT_LENGTH - 1);
  localparam logic [LW:0]   FRAME      = (LW+1)'(FFT_LENGTH);
  localparam logic [BW-1:0] LAST_BIN   = BW'(MAG_BINS - 1);
  localparam logic [BW-1:0] BIN_ONE    = BW'(1);
  localparam logic [GW-1:0] GAP_MAX    = GW'(SAMPLE_GAP);
  localparam logic [RW-1:0] RST_LAST   = RW'(FFT_RST_CYCLES - 1);
  localparam logic [AW:0]   FULL       = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, FFT_RST, FILL, WAIT_FFT, READOUT, REPORT} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [LW-1:0]   issue_q, issue_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d, count;
  logic [BW-1:0]   bin_q, bin_d, best_bin_q, best_bin_d, peak_bin_q, peak_bin_d;
  logic [15:0]     best_mag_q, best_mag_d, peak_mag_q, peak_mag_d, fft_in_real_q, fft_in_real_d;
  logic            fft_reset_q, fft_reset_d, fft_in_valid_q, fft_in_valid_d;
  logic            peak_valid_q, peak_valid_d, busy_q, busy_d, overflow_q, overflow_d;
  logic            abort, fill, full, room, pop, take, push, mag_take, better;
  logic [11:0]     mem [FIFO_DEPTH];

  // start low aborts every active state; REPORT finishes its pulse and IDLE just stays put
  assign abort    = !start_i && state_q != IDLE && state_q != REPORT;
  assign fill     = state_q == FILL && start_i;
  assign count    = wr_q - rd_q;
  assign full     = count == FULL;
  // issued plus buffered must stay below the frame length for a new sample to be considered
  assign room     = {1'b0, issue_q} + (LW+1)'(count) < FRAME;
  // the gap counter rests at its maximum on FILL entry, so the first issue is never held back
  assign pop      = fill && count != '0 && gap_q == GAP_MAX;
  assign take     = fill && adc_data_valid_i && room;
  assign push     = take && (!full || pop);
  assign mag_take = state_q == READOUT && start_i && mag_ready_i;
  assign better   = mag_take && bin_q != '0 && mag_i > best_mag_q;

  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE:     state_d = start_i ? FFT_RST : IDLE;
      FFT_RST:  state_d = rst_cnt_q == RST_LAST ? FILL : FFT_RST;
      FILL:     state_d = pop && issue_q == LAST_ISSUE ? WAIT_FFT : FILL;
      WAIT_FFT: state_d = fft_done_i ? READOUT : WAIT_FFT;
      READOUT:  state_d = mag_take && bin_q == LAST_BIN ? REPORT : READOUT;
      REPORT:   state_d = start_i ? FFT_RST : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign rst_cnt_d      = state_q == FFT_RST && state_d == FFT_RST ? rst_cnt_q + 1'b1 : '0;
  assign issue_d        = abort ? '0 : pop ? issue_q + 1'b1 : issue_q;
  assign gap_d          = state_q != FILL || abort ? GAP_MAX : pop ? GW'(1) : gap_q == GAP_MAX ? gap_q : gap_q + 1'b1;
  assign wr_d           = abort ? '0 : push ? wr_q + 1'b1 : wr_q;
  assign rd_d           = abort ? '0 : pop ? rd_q + 1'b1 : rd_q;
  assign bin_d          = state_q != READOUT || abort ? '0 : mag_take ? bin_q + 1'b1 : bin_q;
  // outside READOUT the running peak idles at bin 1 / value 0, which is its value on entry
  assign best_bin_d     = state_q != READOUT ? BIN_ONE : better ? bin_q : best_bin_q;
  assign best_mag_d     = state_q != READOUT ? '0 : better ? mag_i : best_mag_q;
  assign fft_reset_d    = state_d == IDLE || state_d == FFT_RST;
  assign fft_in_valid_d = pop;
  assign fft_in_real_d  = pop ? {mem[rd_q[AW-1:0]], 4'b0000} : fft_in_real_q;
  assign peak_valid_d   = state_d == REPORT;
  assign peak_bin_d     = peak_valid_d ? best_bin_d : peak_bin_q;
  assign peak_mag_d     = peak_valid_d ? best_mag_d : peak_mag_q;
  assign busy_d         = state_d != IDLE;
  assign overflow_d     = overflow_q | (take && full && !pop);

  always_ff @(posedge clk_i)
    if (push) mem[wr_q[AW-1:0]] <= adc_data_i;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q        <= IDLE;
      rst_cnt_q      <= '0;
      issue_q        <= '0;
      gap_q          <= GAP_MAX;
      wr_q           <= '0;
      rd_q           <= '0;
      bin_q          <= '0;
      best_bin_q     <= BIN_ONE;
      best_mag_q     <= '0;
      fft_reset_q    <= 1'b1;
      fft_in_valid_q <= 1'b0;
      fft_in_real_q  <= '0;
      peak_valid_q   <= 1'b0;
      peak_bin_q     <= '0;
      peak_mag_q     <= '0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      issue_q        <= issue_d;
      gap_q          <= gap_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      bin_q          <= bin_d;
      best_bin_q     <= best_bin_d;
      best_mag_q     <= best_mag_d;
      fft_reset_q    <= fft_reset_d;
      fft_in_valid_q <= fft_in_valid_d;
      fft_in_real_q  <= fft_in_real_d;
      peak_valid_q   <= peak_valid_d;
      peak_bin_q     <= peak_bin_d;
      peak_mag_q     <= peak_mag_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
    end

  assign fft_reset_o    = fft_reset_q;
  assign fft_in_valid_o = fft_in_valid_q;
  assign fft_in_real_o  = fft_in_real_q;
  assign peak_valid_o   = peak_valid_q;
  assign peak_bin_o     = peak_bin_q;
  assign peak_mag_o     = peak_mag_q;
  assign busy_o         = busy_q;
  assign overflow_o     = overflow_q;
endmodule
